// File: rtl/fpu_pkg.sv
// Shared floating-point constants, the special-case class and its decoder.
package fpu_pkg;

   // Pipeline depth of the fsqrt datapath, in rising edges from x to y.
   localparam int FSQRT_LAT = 3;

   // Canonical quiet NaN returned for negative non-zero operands.
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Special-case class carried alongside each request.
   typedef enum logic [1:0] {
      SC_NONE = 2'd0,
      SC_NEG  = 2'd1,
      SC_PASS = 2'd2,
      SC_ZERO = 2'd3
   } sc_e;

   // Classify an operand. Negative non-zero wins over Inf/NaN, so -Inf and
   // negative NaNs both return the canonical quiet NaN.
   function automatic sc_e sc_decode(input logic [31:0] x);
      sc_e sc;
      sc = SC_NONE;
      if (x[31] && (x[30:23] != 8'd0)) begin
         sc = SC_NEG;
      end else if (x[30:23] == 8'hFF) begin
         sc = SC_PASS;
      end else if (x[30:23] == 8'd0) begin
         sc = SC_ZERO;
      end
      return sc;
   endfunction

endpackage

// File: rtl/fsqrt.sv
// Three-stage single-precision square root for positive normal operands.
// Stage 1 unpacks and folds an odd exponent into the significand, stage 2
// extracts a 25-bit integer root, stage 3 rounds to nearest and packs.
// Results for zero, denormal, Inf, NaN and negative inputs are meaningless
// here; the controller overrides them. No enable and no reset.
module fsqrt
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic [31:0] x,
   output logic [31:0] y
);

   logic [24:0] rad_q;
   logic [23:0] root_q;
   logic [7:0]  er_q [FSQRT_LAT-1];
   logic [8:0]  er_sum;
   logic [22:0] frac_rnd;
   logic        unused_sign;

   // The sign never reaches the datapath result: negatives are overridden.
   assign unused_sign = x[31];

   // Result exponent: (e + 127) / 2 for odd e, (e + 126) / 2 for even e.
   assign er_sum = {1'b0, x[30:23]} + 9'd126 + {8'd0, x[23]};

   // Round to nearest using the extra root bit; a tie cannot occur because
   // the scaled radicand is a multiple of 4 and never an odd square.
   assign frac_rnd = root_q[23:1] + {22'd0, root_q[0]};

   // Digit-by-digit integer square root of a 50-bit radicand.
   function automatic logic [24:0] isqrt50(input logic [49:0] rad);
      logic [27:0] rem;
      logic [27:0] trial;
      logic [24:0] root;
      rem  = '0;
      root = '0;
      for (int i = 24; i >= 0; i--) begin
         rem   = {rem[25:0], rad[2*i +: 2]};
         trial = {1'b0, root, 2'b01};
         if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[23:0], 1'b1};
         end else begin
            root = {root[23:0], 1'b0};
         end
      end
      return root;
   endfunction

   // Stage 1: significand 1.m (odd e) or 2 x 1.m (even e), plus exponent.
   always_ff @(posedge clk) begin
      rad_q   <= x[23] ? {2'b01, x[22:0]} : {1'b1, x[22:0], 1'b0};
      er_q[0] <= 8'(er_sum >> 1);
   end

   // Stage 2: root carries 24 fraction bits; its leading one is implicit.
   always_ff @(posedge clk) begin
      root_q <= 24'(isqrt50({rad_q, 25'd0}));
      for (int k = 1; k < FSQRT_LAT - 1; k++) begin
         er_q[k] <= er_q[k-1];
      end
   end

   // Stage 3: pack the rounded result.
   always_ff @(posedge clk) begin
      y <= {1'b0, er_q[FSQRT_LAT-2], frac_rnd};
   end

endmodule

// File: rtl/fsqrt_ofifo.sv
// Synchronous result FIFO. A written entry becomes visible at the head the
// cycle after the write (no fall-through). DEPTH must be a power of two so
// the pointers wrap naturally. Storage is not reset; the head reads as zero
// while empty.
module fsqrt_ofifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          do_rd;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_rd   = rd_en && !empty;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage write; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; a write and a read in one cycle both apply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(wr_en) - CW'(do_rd);
      end
   end

   // The upstream credit scheme guarantees a free slot for every write.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/fsqrt_ctrl.sv
// Flow-control wrapper around the fsqrt datapath. A shadow pipeline tracks
// which datapath slots hold live requests together with their tag, special
// case class and raw operand; live results land in the output FIFO three
// edges after acceptance. A credit counter covering in-flight requests and
// FIFO occupancy makes FIFO overflow impossible.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on registered state; out_valid/out_data/
// out_tag hold steady while out_valid is high and out_ready is low.
module fsqrt_ctrl
   import fpu_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int FW = 32 + TAG_W;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      sc_e              sc;
      logic [31:0]      raw;
   } shadow_t;

   logic [FSQRT_LAT-1:0] vld_q;
   shadow_t              sh_q [FSQRT_LAT];
   logic [CW-1:0]        cnt;
   logic                 accept;
   logic                 pop;
   logic [31:0]          y;
   logic [31:0]          res;
   shadow_t              tail;
   logic [FW-1:0]        head;
   logic                 fifo_empty;

   assign in_ready  = (cnt < CW'(DEPTH));
   assign accept    = in_valid && in_ready;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign tail      = sh_q[FSQRT_LAT-1];
   assign out_data  = head[FW-1:TAG_W];
   assign out_tag   = head[TAG_W-1:0];

   fsqrt u_fsqrt (
      .clk (clk),
      .x   (in_data),
      .y   (y)
   );

   // Shadow valid bits: the only pipeline state that needs clearing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[FSQRT_LAT-2:0], accept};
      end
   end

   // Shadow payload follows the datapath stages; meaningful only when valid.
   always_ff @(posedge clk) begin
      sh_q[0] <= '{tag: in_tag, sc: sc_decode(in_data), raw: in_data};
      for (int k = 1; k < FSQRT_LAT; k++) begin
         sh_q[k] <= sh_q[k-1];
      end
   end

   // Credits: one taken per accept, one returned per pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Special-case override of the datapath result at FIFO write.
   always_comb begin
      res = y;
      case (tail.sc)
         SC_NEG:  res = QNAN;
         SC_PASS: res = tail.raw;
         SC_ZERO: res = {tail.raw[31], 31'd0};
         default: res = y;
      endcase
   end

   fsqrt_ofifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_ofifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (vld_q[FSQRT_LAT-1]),
      .wr_data ({res, tail.tag}),
      .rd_en   (out_ready),
      .rd_data (head),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_fsqrt_ctrl.sv
// Bench for fsqrt_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the result stream.
module tb_fsqrt_ctrl;
   import fpu_pkg::*;

   localparam int TAG_W = 4;
   localparam int DEPTH = 4;
   localparam int W     = 32 + TAG_W;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   always #5 clk = ~clk;

   fsqrt_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   int n_pass  = 0;
   int n_total = 0;
   int edge_cnt = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic longint isqrt_ref(input longint v);
      longint lo, hi, mid;
      lo = 0;
      hi = longint'(1) << 26;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= v) lo = mid;
         else hi = mid;
      end
      return lo;
   endfunction

   // Correctly rounded sqrt for positive normals, special cases by rule.
   function automatic logic [31:0] model_result(input logic [31:0] x);
      logic [7:0]  e;
      int          ex;
      longint      sig, r, rounded;
      logic [63:0] rl;
      logic [31:0] res;
      e = x[30:23];
      if (x[31] && e != 8'd0) return QNAN;
      if (e == 8'hFF) return x;
      if (e == 8'd0) return {x[31], 31'd0};
      ex  = int'(e) - 127;
      sig = longint'({1'b1, x[22:0]});
      if (ex % 2 != 0) begin
         sig = sig * 2;
         ex  = ex - 1;
      end
      r       = isqrt_ref(sig * (longint'(1) << 25));
      rounded = r / 2 + r % 2;
      rl      = rounded;
      res     = {1'b0, 8'(ex / 2 + 127), rl[22:0]};
      return res;
   endfunction

   logic [W-1:0] exp_q[$];      // results visible in the output buffer
   logic [W-1:0] pipe_q[$];     // accepted, not yet written
   int           due_q[$];      // edge at which each pipe_q entry is written
   int           mcnt = 0;
   logic [W-1:0] pop_q[$];      // what the DUT actually delivered
   int           pop_edge_q[$];
   int           acc_edge_q[$];
   int           nxt;
   bit           m_acc, m_pop;

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_data", out_data, 0);
         chk("rst_out_tag", out_tag, 0);
         chk("rst_cnt", u_dut.cnt, 0);
         exp_q.delete();
         pipe_q.delete();
         due_q.delete();
         mcnt = 0;
      end else begin
         nxt = edge_cnt + 1;
         chk("in_ready", in_ready, mcnt < DEPTH);
         chk("out_valid", out_valid, exp_q.size() != 0);
         chk("cnt", u_dut.cnt, mcnt);
         if (exp_q.size() != 0) chk("out_head", {out_data, out_tag}, exp_q[0]);
         if (in_valid && in_ready) acc_edge_q.push_back(nxt);
         if (out_valid && out_ready) begin
            pop_q.push_back({out_data, out_tag});
            pop_edge_q.push_back(nxt);
         end
         m_acc = in_valid && (mcnt < DEPTH);
         m_pop = out_ready && (exp_q.size() != 0);
         if (m_pop) void'(exp_q.pop_front());
         while (due_q.size() != 0 && due_q[0] == nxt) begin
            exp_q.push_back(pipe_q.pop_front());
            void'(due_q.pop_front());
         end
         if (m_acc) begin
            pipe_q.push_back({model_result(in_data), in_tag});
            due_q.push_back(nxt + 3);
         end
         mcnt = mcnt + int'(m_acc) - int'(m_pop);
      end
   end

   function automatic logic [63:0] pop_at(input int i);
      if (i < pop_q.size()) return 64'(pop_q[i]);
      return '1;
   endfunction

   function automatic int pop_edge_at(input int i);
      if (i < pop_edge_q.size()) return pop_edge_q[i];
      return -1000;
   endfunction

   function automatic int acc_edge_at(input int i);
      if (i < acc_edge_q.size()) return acc_edge_q[i];
      return 1000;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] d, input logic [TAG_W-1:0] t);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_tag   = t;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_total++;
         $display("FAIL send_timeout: in_ready 0 after 100 cycles, expected 1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      case ($urandom_range(0, 9))
         0:       v = {1'b1, 8'($urandom_range(1, 255)), 23'($urandom)};
         1:       v = {1'b0, 8'hFF, 23'($urandom)};
         2:       v = {1'($urandom), 8'h00, 23'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
         default: v = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
      return v;
   endfunction

   int a0, p0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;

      // Hand-computed values pinning the model.
      chk("model_4", model_result(32'h40800000), 32'h40000000);
      chk("model_9", model_result(32'h41100000), 32'h40400000);
      chk("model_2", model_result(32'h40000000), 32'h3FB504F3);
      chk("model_neg0", model_result(32'h80000000), 32'h80000000);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      wait_cycles(1);

      // Single request: latency and result.
      a0 = acc_edge_q.size(); p0 = pop_q.size();
      send(32'h40800000, 4'd3);
      idle();
      wait_cycles(8);
      chk("t1_pop_count", pop_q.size() - p0, 1);
      chk("t1_result", pop_at(p0), {32'h40000000, 4'd3});
      chk("t1_latency", pop_edge_at(p0) - acc_edge_at(a0), 4);

      // Back-to-back requests, consecutive results.
      p0 = pop_q.size();
      send(32'h41100000, 4'd1);
      send(32'h3F800000, 4'd2);
      send(32'h00000000, 4'd3);
      send(32'h80000000, 4'd4);
      idle();
      wait_cycles(10);
      chk("t2_r0", pop_at(p0),     {32'h40400000, 4'd1});
      chk("t2_r1", pop_at(p0 + 1), {32'h3F800000, 4'd2});
      chk("t2_r2", pop_at(p0 + 2), {32'h00000000, 4'd3});
      chk("t2_r3", pop_at(p0 + 3), {32'h80000000, 4'd4});
      for (int k = 0; k < 3; k++)
         chk("t2_consecutive", pop_edge_at(p0 + k + 1) - pop_edge_at(p0 + k), 1);

      // Special cases.
      p0 = pop_q.size();
      send(32'hC0800000, 4'd5);
      send(32'h7F800000, 4'd6);
      send(32'h7FC00001, 4'd7);
      idle();
      wait_cycles(10);
      chk("t3_neg",  pop_at(p0),     {32'h7FC00000, 4'd5});
      chk("t3_inf",  pop_at(p0 + 1), {32'h7F800000, 4'd6});
      chk("t3_nan",  pop_at(p0 + 2), {32'h7FC00001, 4'd7});

      // Backpressure: only DEPTH accepted while the consumer stalls.
      out_ready = 1'b0;
      a0 = acc_edge_q.size(); p0 = pop_q.size();
      send(32'h40800000, 4'd8);
      send(32'h41100000, 4'd9);
      send(32'h3F800000, 4'd10);
      send(32'h7F800000, 4'd11);
      in_valid = 1'b1; in_data = 32'h00000000; in_tag = 4'd12;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t4_in_ready_low", in_ready, 0);
         @(posedge clk);
         #1;
      end
      chk("t4_accepted", acc_edge_q.size() - a0, 4);
      out_ready = 1'b1;
      send(32'h00000000, 4'd12);
      send(32'hC0800000, 4'd13);
      idle();
      wait_cycles(12);
      chk("t4_accepted_all", acc_edge_q.size() - a0, 6);
      chk("t4_r0", pop_at(p0),     {32'h40000000, 4'd8});
      chk("t4_r1", pop_at(p0 + 1), {32'h40400000, 4'd9});
      chk("t4_r2", pop_at(p0 + 2), {32'h3F800000, 4'd10});
      chk("t4_r3", pop_at(p0 + 3), {32'h7F800000, 4'd11});
      chk("t4_r4", pop_at(p0 + 4), {32'h00000000, 4'd12});
      chk("t4_r5", pop_at(p0 + 5), {32'h7FC00000, 4'd13});

      // Accept and pop together starting at cnt = DEPTH-1.
      out_ready = 1'b0;
      a0 = acc_edge_q.size(); p0 = pop_q.size();
      for (int k = 0; k < 3; k++) send(rand_operand(), 4'(k));
      idle();
      wait_cycles(5);
      @(negedge clk);
      chk("t5_cnt_start", u_dut.cnt, DEPTH - 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) send(rand_operand(), 4'(k));
      idle();
      wait_cycles(10);
      chk("t5_accepts", acc_edge_q.size() - a0, 23);
      chk("t5_pops", pop_q.size() - p0, 23);

      // Reset with two results buffered and two in flight.
      out_ready = 1'b0;
      send(32'h40800000, 4'd1);
      send(32'h41100000, 4'd2);
      idle();
      wait_cycles(5);
      send(32'h3F800000, 4'd3);
      send(32'h40000000, 4'd4);
      idle();
      rst_n = 1'b0;
      #1;
      chk("t6_out_valid_async", out_valid, 0);
      chk("t6_in_ready_async", in_ready, 1);
      chk("t6_out_data_async", out_data, 0);
      wait_cycles(2);
      p0 = pop_q.size();
      rst_n = 1'b1;
      out_ready = 1'b1;
      wait_cycles(10);
      chk("t6_no_stale", pop_q.size() - p0, 0);

      // Randomized traffic.
      a0 = acc_edge_q.size(); p0 = pop_q.size();
      for (int k = 0; k < 300; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = rand_operand();
         in_tag    = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      idle();
      out_ready = 1'b1;
      wait_cycles(12);
      chk("rand_drained_cnt", u_dut.cnt, 0);
      chk("rand_drained_valid", out_valid, 0);
      chk("rand_balance", pop_q.size() - p0, acc_edge_q.size() - a0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
